iomem_fabric: RTL and testbench
===============================

IOMEM_FABRIC -- requirements
Module: iomem_fabric

Interface
REQ-001 SHALL have parameter N_SLOTS, default 3: number of peripheral slots decoded from iomem_addr[27:24], legal range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: WAIT cycles before timeout, legal range 2..65535.
REQ-003 SHALL have parameter UNMAPPED_DATA, default 32'hFFFFFFFF: read data returned for unmapped slots.
REQ-004 SHALL have parameter TIMEOUT_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous, active-high).
REQ-006 SHALL have master-side ports: iomem_valid (in, 1), iomem_ready (out, 1), iomem_wstrb (in, 4), iomem_addr (in, 32), iomem_wdata (in, 32), iomem_rdata (out, 32).
REQ-007 SHALL have slave-side ports: s_sel (out, N_SLOTS, one-hot), s_ready (in, N_SLOTS), s_rdata (in, 32*N_SLOTS; slot k at [32k+31:32k]), s_addr (out, 32), s_wdata (out, 32), s_wstrb (out, 4).
REQ-008 SHALL have status ports: err_clr (in, 1), err_count (out, 16), err_addr (out, 32).

Function
REQ-009 SHALL implement an FSM with states IDLE, WAIT and RESP, and at most one transaction outstanding.
REQ-010 IDLE with iomem_valid=1 and slot=iomem_addr[27:24]<N_SLOTS: next cycle SHALL be WAIT with s_sel[slot]=1 (registered).
REQ-011 IDLE with iomem_valid=1 and slot>=N_SLOTS: next cycle SHALL be RESP with rdata=UNMAPPED_DATA; no s_sel asserted; counted as an error.
REQ-012 s_addr, s_wdata and s_wstrb SHALL be registered copies of the master fields, captured on the IDLE->WAIT transition and held stable through WAIT.
REQ-013 WAIT with s_ready[slot]=1: SHALL capture s_rdata slot k into the response register, drop s_sel, and go to RESP.
REQ-014 RESP SHALL drive iomem_ready=1 for exactly one cycle with iomem_rdata=the response register, then go to IDLE.
REQ-015 iomem_rdata SHALL be 0 whenever iomem_ready=0.
REQ-016 Minimum latency SHALL be: valid sampled in cycle 0, s_sel in cycle 1, slave ready in cycle 1, iomem_ready in cycle 2.
REQ-017 s_ready bits of unselected slots SHALL be ignored.
REQ-018 Writes (wstrb!=0) SHALL follow the same handshake; the response register SHALL still load s_rdata (master ignores it).
REQ-019 iomem_valid dropping in WAIT SHALL return the FSM to IDLE next cycle: s_sel cleared, no iomem_ready, no error counted.
REQ-020 err_count SHALL increment by 1 per error and saturate at 16'hFFFF.
REQ-021 err_addr SHALL be loaded with the faulting iomem_addr on every error.
REQ-022 err_clr=1 SHALL zero err_count; err_clr coincident with an error SHALL yield err_count=1.

Reset
REQ-023 On reset: FSM=IDLE, iomem_ready=0, iomem_rdata=0, s_sel=0, s_addr/s_wdata/s_wstrb=0, err_count=0, err_addr=0, timeout counter=0.
REQ-024 Reset asserted mid-transaction SHALL abandon it with no response issued; the first cycle after reset deasserts SHALL be IDLE.

Configuration
REQ-025 Macro IOMEM_FABRIC_TIMEOUT_EN SHALL control the timeout feature.
REQ-026 IOMEM_FABRIC_TIMEOUT_EN defined: a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-027 IOMEM_FABRIC_TIMEOUT_EN defined: on the WAIT cycle where the counter equals TIMEOUT_CYCLES-1 and s_ready[slot]=0, the FSM SHALL go to RESP with rdata=TIMEOUT_DATA, drop s_sel, and count an error.
REQ-028 IOMEM_FABRIC_TIMEOUT_EN defined: s_ready arriving on that same cycle SHALL win, giving normal data and no error.
REQ-029 IOMEM_FABRIC_TIMEOUT_EN undefined: WAIT SHALL persist until s_ready or valid drop; no counter logic; unmapped errors still counted.

Verification
REQ-030 Read addr 0x22000004, slot 2 ready in cycle 1 with rdata 0x12345678 -> s_sel=3'b100 in cycle 1, iomem_ready in cycle 2, rdata 0x12345678, err_count 0.
REQ-031 N_SLOTS=3, read addr 0x25000000 -> iomem_ready in cycle 1, rdata 0xFFFFFFFF, s_sel stays 0, err_count=1, err_addr=0x25000000.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=4, slot 0 never ready -> s_sel[0] high 4 cycles, then ready with 0xDEADBEEF, err_count=1; s_ready on the 4th WAIT cycle -> slave data, no error.
REQ-033 Write 0x21000010, wstrb 4'hF, wdata 0xCAFEF00D, slot 1 ready after 3 WAIT cycles -> s_wdata/s_wstrb held stable throughout WAIT, one iomem_ready pulse.
REQ-034 Preload err_count=16'hFFFF, then one unmapped access -> err_count stays 16'hFFFF; err_clr coincident with an error -> err_count=1.
REQ-035 Reset asserted during WAIT -> s_sel=0 next cycle, no iomem_ready pulse, the next valid is handled normally.

Source files
------------

// File: rtl/iomem_fabric.sv
// Purpose : single-outstanding address decoder between a PicoRV32-style iomem master and N_SLOTS
//           peripheral slots (slot = iomem_addr[27:24]), with error counting and optional WAIT timeout.
// Latency : mapped access answers at least 2 cycles after valid is sampled; unmapped access answers after 1 cycle.
// Backpressure: a slot holds the fabric in WAIT by keeping s_ready low; the master is stalled until iomem_ready.
// Optional feature macro: IOMEM_FABRIC_TIMEOUT_EN enables the WAIT timeout counter.
//
// Ports:
//   clk, reset         sole clock, synchronous active-high reset
//   iomem_valid/ready  master handshake; iomem_rdata is zero except in the one-cycle ready pulse
//   iomem_wstrb/addr/wdata  master request fields (wstrb != 0 means write)
//   s_sel              one-hot registered slot select (held through WAIT)
//   s_ready/s_rdata    per-slot completion and read data (slot k at s_rdata[32k+31:32k])
//   s_addr/wdata/wstrb registered copies of the request, stable for the whole WAIT phase
//   err_clr            clears err_count (an error in the same cycle leaves it at 1)
//   err_count/err_addr saturating error counter and address of the most recent error
module iomem_fabric #(
    parameter int          N_SLOTS        = 3,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] UNMAPPED_DATA  = 32'hFFFF_FFFF,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,

    output logic [N_SLOTS-1:0]      s_sel,
    input  logic [N_SLOTS-1:0]      s_ready,
    input  logic [32*N_SLOTS-1:0]   s_rdata,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,

    input  logic                    err_clr,
    output logic [15:0]             err_count,
    output logic [31:0]             err_addr
);

    // Elaboration-time guard on the legal parameter ranges.
    if (N_SLOTS < 1 || N_SLOTS > 16) begin : g_bad_n_slots
        $error("iomem_fabric: N_SLOTS out of range 1..16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("iomem_fabric: TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;

    logic [3:0]          slot;
    logic                mapped;
    logic [N_SLOTS-1:0]  sel_dec;
    logic                sel_ready;
    logic [31:0]         slot_rdata;
    logic                to_hit;
    logic                err_unmapped;
    logic                err_timeout;
    logic                err_evt;
    logic [31:0]         err_src_addr;

    assign slot   = iomem_addr[27:24];
    assign mapped = ({1'b0, slot} < 5'(N_SLOTS));

    always_comb begin
        sel_dec = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            sel_dec[k] = (slot == 4'(k));
        end
    end

    // s_sel is one-hot (or zero), so masking with it selects the active slot's
    // ready/data and ignores everything from unselected slots.
    assign sel_ready = |(s_ready & s_sel);

    always_comb begin
        slot_rdata = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (s_sel[k]) begin
                slot_rdata = slot_rdata | s_rdata[32*k +: 32];
            end
        end
    end

`ifdef IOMEM_FABRIC_TIMEOUT_EN
    // Counts completed WAIT cycles of the current access; the cycle where it
    // reads TIMEOUT_CYCLES-1 is the last WAIT cycle allowed.
    logic [15:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= 16'd0;
        end else if (state == ST_IDLE) begin
            to_cnt <= 16'd0;
        end else if (state == ST_WAIT) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Error sources. A valid drop in WAIT is an abort, never an error, and a
    // slave ready on the final WAIT cycle beats the timeout.
    assign err_unmapped = (state == ST_IDLE) && iomem_valid && !mapped;
    assign err_timeout  = (state == ST_WAIT) && iomem_valid && !sel_ready && to_hit;
    assign err_evt      = err_unmapped || err_timeout;
    assign err_src_addr = err_unmapped ? iomem_addr : s_addr;

    // Transaction FSM; every output it drives is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
            s_sel       <= '0;
            s_addr      <= 32'd0;
            s_wdata     <= 32'd0;
            s_wstrb     <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'd0;
                    if (iomem_valid) begin
                        if (mapped) begin
                            s_sel   <= sel_dec;
                            s_addr  <= iomem_addr;
                            s_wdata <= iomem_wdata;
                            s_wstrb <= iomem_wstrb;
                            state   <= ST_WAIT;
                        end else begin
                            iomem_ready <= 1'b1;
                            iomem_rdata <= UNMAPPED_DATA;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!iomem_valid) begin
                        s_sel <= '0;
                        state <= ST_IDLE;
                    end else if (sel_ready) begin
                        // Writes also load the slot data; the master ignores it.
                        s_sel       <= '0;
                        iomem_ready <= 1'b1;
                        iomem_rdata <= slot_rdata;
                        state       <= ST_RESP;
                    end else if (to_hit) begin
                        s_sel       <= '0;
                        iomem_ready <= 1'b1;
                        iomem_rdata <= TIMEOUT_DATA;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'd0;
                    state       <= ST_IDLE;
                end
                default: begin
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'd0;
                    s_sel       <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating error counter. The saturated value is rewritten explicitly
    // so the register is always assigned when an error occurs.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 16'd0;
            err_addr  <= 32'd0;
        end else begin
            if (err_clr) begin
                err_count <= err_evt ? 16'd1 : 16'd0;
            end else if (err_evt) begin
                err_count <= (err_count == 16'hFFFF) ? 16'hFFFF : err_count + 16'd1;
            end
            if (err_evt) begin
                err_addr <= err_src_addr;
            end
        end
    end

endmodule

// File: tb/tb_iomem_fabric.sv
// Purpose : self-checking bench for iomem_fabric (N_SLOTS=3, TIMEOUT_CYCLES=4).
// Latency : checks response latency per transaction against a transaction-level model.
// Backpressure: slave readiness is modelled as a per-transaction WAIT-cycle delay.
module tb_iomem_fabric;

    localparam int          NS  = 3;
    localparam int          TC  = 4;
    localparam logic [31:0] UNM = 32'hFFFF_FFFF;
    localparam logic [31:0] TOD = 32'hDEAD_BEEF;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              iomem_valid;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;
    logic [NS-1:0]     s_sel;
    logic [NS-1:0]     s_ready;
    logic [32*NS-1:0]  s_rdata;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              err_clr;
    logic [15:0]       err_count;
    logic [31:0]       err_addr;

    iomem_fabric #(
        .N_SLOTS(NS), .TIMEOUT_CYCLES(TC), .UNMAPPED_DATA(UNM), .TIMEOUT_DATA(TOD)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .s_sel(s_sel), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;
    logic [31:0] exp_erra = 32'd0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_errc;
        logic [31:0] exp_erra;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: latency, data and whether it is an error.
    task automatic model_txn(input logic [31:0] addr, input int delay, input logic [31:0] sdata,
                             output int lat, output logic [31:0] data, output bit is_err);
        int waits;
        if (int'(addr[27:24]) >= NS) begin
            lat = 1; data = UNM; is_err = 1'b1;
        end else begin
            waits = delay + 1;
            if (TO_EN && waits > TC) begin
                lat = TC + 1; data = TOD; is_err = 1'b1;
            end else begin
                lat = waits + 1; data = sdata; is_err = 1'b0;
            end
        end
    endtask

    task automatic model_err(input bit is_err, input logic [31:0] addr);
        if (is_err) begin
            exp_err  = (exp_err >= 65535) ? 65535 : exp_err + 1;
            exp_erra = addr;
        end
    endtask

    // Drives one master transaction; the addressed slot raises s_ready on WAIT
    // cycle delay+1 while the other slots toggle s_ready randomly.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                           input int delay, input logic [31:0] sdata,
                           output int lat, output logic [31:0] rdat, output bit sel_ok, output bit hold_ok);
        int          slot;
        bit          mapped;
        logic [NS-1:0] onehot;
        int          c;
        slot    = int'(addr[27:24]);
        mapped  = (slot < NS);
        onehot  = '0;
        if (mapped) onehot[slot] = 1'b1;
        lat = -1; rdat = 32'd0; sel_ok = 1'b1; hold_ok = 1'b1; c = 0;
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
        s_ready = NS'($urandom) & ~onehot;
        for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = $urandom;
        while (c < 200) begin
            step();
            c++;
            if (iomem_ready === 1'b1) begin
                lat = c; rdat = iomem_rdata;
                if (s_sel !== '0) sel_ok = 1'b0;
                break;
            end
            if (iomem_rdata !== 32'd0) sel_ok = 1'b0;
            if (s_sel !== onehot) sel_ok = 1'b0;
            if (mapped && (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb)) hold_ok = 1'b0;
            for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = $urandom;
            if (mapped) s_rdata[32*slot +: 32] = sdata;
            s_ready = NS'($urandom) & ~onehot;
            if (mapped && c == delay + 1) s_ready = s_ready | onehot;
        end
        iomem_valid = 1'b0; s_ready = '0;
        step();
        if (iomem_ready !== 1'b0 || iomem_rdata !== 32'd0 || s_sel !== '0) sel_ok = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rdat;
        bit          sel_ok, hold_ok, is_err;
        int          m_lat;
        logic [31:0] m_data;
        logic [31:0] a, wd, sd;
        logic [3:0]  ws;
        int          dly;

        tbl[0] = '{32'h2200_0004, 4'h0, 32'h0,         0, 32'h1234_5678, 2, 32'h1234_5678, 0, 32'h0};
        tbl[1] = '{32'h2500_0000, 4'h0, 32'h0,         0, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1, 32'h2500_0000};
        tbl[2] = '{32'h2100_0010, 4'hF, 32'hCAFE_F00D, 3, 32'h0BAD_F00D, 5, 32'h0BAD_F00D, 1, 32'h2500_0000};
        tbl[3] = '{32'h3000_0008, 4'h0, 32'h0,         1, 32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 1, 32'h2500_0000};
        tbl[4] = '{32'h0300_0000, 4'h0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFF, 2, 32'h0300_0000};
        tbl[5] = '{32'h0F00_FFFC, 4'h3, 32'h1122_3344, 0, 32'h0,         1, 32'hFFFF_FFFF, 3, 32'h0F00_FFFC};
        tbl[6] = '{32'h2000_00F0, 4'h1, 32'h0000_0055, 2, 32'h5A5A_5A5A, 4, 32'h5A5A_5A5A, 3, 32'h0F00_FFFC};

        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 32'h0;
        iomem_wdata = 32'h0; s_ready = '0; s_rdata = '0; err_clr = 1'b0;
        step(); step();
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_sel", 32'(s_sel), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;
        step();

        // Table-driven directed transactions.
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].delay, tbl[i].sdata,
                    lat, rdat, sel_ok, hold_ok);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("tbl%0d_rdata", i), rdat, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_sel", i), 32'(sel_ok), 32'd1);
            check($sformatf("tbl%0d_hold", i), 32'(hold_ok), 32'd1);
            check($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(tbl[i].exp_errc));
            check($sformatf("tbl%0d_err_addr", i), err_addr, tbl[i].exp_erra);
        end
        exp_err = 3; exp_erra = 32'h0F00_FFFC;

        // Slot 0 that never answers in time.
`ifdef IOMEM_FABRIC_TIMEOUT_EN
        run_txn(32'h2000_0000, 4'h0, 32'h0, 100, 32'h7777_7777, lat, rdat, sel_ok, hold_ok);
        check("timeout_lat", 32'(lat), 32'd5);
        check("timeout_rdata", rdat, 32'hDEAD_BEEF);
        check("timeout_sel", 32'(sel_ok), 32'd1);
        check("timeout_err_count", 32'(err_count), 32'd4);
        check("timeout_err_addr", err_addr, 32'h2000_0000);
        exp_err = 4; exp_erra = 32'h2000_0000;
`else
        run_txn(32'h2000_0000, 4'h0, 32'h0, 20, 32'h7777_7777, lat, rdat, sel_ok, hold_ok);
        check("longwait_lat", 32'(lat), 32'd22);
        check("longwait_rdata", rdat, 32'h7777_7777);
        check("longwait_sel", 32'(sel_ok), 32'd1);
        check("longwait_err_count", 32'(err_count), 32'd3);
`endif

        // Master abandons the access in WAIT.
        iomem_valid = 1'b1; iomem_addr = 32'h2100_0000; iomem_wstrb = 4'h0; s_ready = '0;
        step();
        check("abort_sel_wait", 32'(s_sel), 32'b010);
        step();
        iomem_valid = 1'b0;
        step();
        check("abort_sel_clr", 32'(s_sel), 32'd0);
        check("abort_no_ready", 32'(iomem_ready), 32'd0);
        step();
        check("abort_no_ready2", 32'(iomem_ready), 32'd0);
        check("abort_err_count", 32'(err_count), 32'(exp_err));

        // err_clr together with an unmapped access leaves exactly one error.
        iomem_valid = 1'b1; iomem_addr = 32'h2500_0000; err_clr = 1'b1;
        step();
        err_clr = 1'b0; iomem_valid = 1'b0;
        check("clr_coinc_ready", 32'(iomem_ready), 32'd1);
        check("clr_coinc_count", 32'(err_count), 32'd1);
        check("clr_coinc_addr", err_addr, 32'h2500_0000);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_alone_count", 32'(err_count), 32'd0);
        exp_err = 0; exp_erra = 32'h2500_0000;

        // Saturation: preload the counter at its ceiling, then add errors.
        force dut.err_count = 16'hFFFF;
        iomem_valid = 1'b1; iomem_addr = 32'h2600_0000;
        step();
        iomem_valid = 1'b0;
        release dut.err_count;
        #1;
        check("sat_count_a", 32'(err_count), 32'h0000_FFFF);
        step();
        run_txn(32'h2700_0000, 4'h0, 32'h0, 0, 32'h0, lat, rdat, sel_ok, hold_ok);
        check("sat_count_b", 32'(err_count), 32'h0000_FFFF);
        check("sat_err_addr", err_addr, 32'h2700_0000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sat_clr", 32'(err_count), 32'd0);
        exp_err = 0; exp_erra = 32'h2700_0000;

        // Reset in the middle of WAIT abandons the access.
        iomem_valid = 1'b1; iomem_addr = 32'h2200_0000; s_ready = '0;
        step();
        check("rstw_sel_before", 32'(s_sel), 32'b100);
        reset = 1'b1;
        step();
        check("rstw_sel", 32'(s_sel), 32'd0);
        check("rstw_ready", 32'(iomem_ready), 32'd0);
        check("rstw_s_addr", s_addr, 32'd0);
        check("rstw_err_addr", err_addr, 32'd0);
        reset = 1'b0;
        exp_err = 0; exp_erra = 32'd0;
        run_txn(32'h2200_0004, 4'h0, 32'h0, 0, 32'h1234_5678, lat, rdat, sel_ok, hold_ok);
        check("rstw_next_lat", 32'(lat), 32'd2);
        check("rstw_next_rdata", rdat, 32'h1234_5678);
        check("rstw_next_sel", 32'(sel_ok), 32'd1);

        // Randomized transactions against the transaction-level model.
        for (int i = 0; i < 60; i++) begin
            a   = $urandom;
            a[27:24] = 4'($urandom_range(0, 4));
            ws  = 4'($urandom);
            wd  = $urandom;
            sd  = $urandom;
            dly = $urandom_range(0, 6);
            model_txn(a, dly, sd, m_lat, m_data, is_err);
            model_err(is_err, a);
            run_txn(a, ws, wd, dly, sd, lat, rdat, sel_ok, hold_ok);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_rdata", i), rdat, m_data);
            check($sformatf("rnd%0d_sel", i), 32'(sel_ok), 32'd1);
            check($sformatf("rnd%0d_hold", i), 32'(hold_ok), 32'd1);
            check($sformatf("rnd%0d_err_count", i), 32'(err_count), 32'(exp_err));
            check($sformatf("rnd%0d_err_addr", i), err_addr, exp_erra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
